// File: rtl/qpsk_pkg.sv
// Shared types and constants for the two-source QPSK demapper arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   N_DEF / MAX_FRAME_DEF - default component width and frame limit
//   SAMPLE_W_DEF          - default packed {I,Q} sample width (2*N)
//   arb_state_e           - arbitration state encoding
//   src_id_t              - source identifier (0 or 1)
//   meta_t                - per-beat sideband carried with each sample
package qpsk_pkg;

   localparam int N_DEF         = 16;
   localparam int MAX_FRAME_DEF = 1024;
   localparam int SAMPLE_W_DEF  = 2 * N_DEF;

   // Packed sample width for a given I/Q component width.
   function automatic int sample_w(input int n);
      return 2 * n;
   endfunction

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   typedef logic src_id_t;

   localparam src_id_t SRC0 = 1'b0;
   localparam src_id_t SRC1 = 1'b1;

   // Sideband travelling alongside each sample through the output stage.
   typedef struct packed {
      logic    last;
      src_id_t src;
   } meta_t;

endpackage

// File: rtl/qpsk_demap_arbiter_axis_out_reg.sv
// Single-stage valid/ready output register holding one sample plus its meta.
// Latency: a beat loaded at a clock edge is presented on the outputs that same cycle (1 cycle from input).
// Backpressure: contents hold while out_vld_o && !out_rdy_i; free_o tells the feeder when a load is allowed.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_vld_i/in_dat_i/in_meta_i - load request and beat; caller asserts in_vld_i only when free_o=1
//   out_rdy_i             - downstream accept
//   out_vld_o/out_dat_o/out_meta_o - registered beat
//   free_o                - register is empty or being drained this cycle
module axis_out_reg
   import qpsk_pkg::*;
#(
   parameter int DW = SAMPLE_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld_i,
   input  logic [DW-1:0] in_dat_i,
   input  meta_t         in_meta_i,
   input  logic          out_rdy_i,
   output logic          out_vld_o,
   output logic [DW-1:0] out_dat_o,
   output meta_t         out_meta_o,
   output logic          free_o
);

   logic          vld_q,  vld_d;
   logic [DW-1:0] dat_q,  dat_d;
   meta_t         meta_q, meta_d;

   // A new beat may enter when the slot is empty or its occupant leaves now.
   assign free_o = !vld_q || out_rdy_i;

   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      meta_d = meta_q;
      if (in_vld_i) begin
         vld_d  = 1'b1;
         dat_d  = in_dat_i;
         meta_d = in_meta_i;
      end else if (out_rdy_i) begin
         // Beat taken and nothing replaces it: release the slot.
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         dat_q  <= '0;
         meta_q <= '0;
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         meta_q <= meta_d;
      end
   end

   assign out_vld_o  = vld_q;
   assign out_dat_o  = dat_q;
   assign out_meta_o = meta_q;

endmodule

// File: rtl/qpsk_demap_arbiter.sv
// Frame-granular round-robin arbiter sharing one QPSK demapper between two sample sources.
// Latency: accepted source beat appears on m_* the next cycle; 1 beat/cycle while m_ready=1; >=1 idle cycle between frames.
// Backpressure: source ready only for the frame owner and only while the output register can take a beat.
//
// Ports:
//   clk, rst                               - clock, synchronous active-high reset
//   s0_data/s0_valid/s0_last/s0_ready      - source 0 {I,Q} sample stream
//   s1_data/s1_valid/s1_last/s1_ready      - source 1 {I,Q} sample stream
//   m_data/m_valid/m_last/m_ready          - to demapper din/din_valid/din_last, from in_ready
//   m_src                                  - source id of the beat on m_data
//   busy                                   - a frame grant is held
//   err_trunc                              - one-cycle pulse, shown with the beat a runaway frame was cut on
module qpsk_demap_arbiter
   import qpsk_pkg::*;
#(
   parameter  int N         = N_DEF,
   parameter  int MAX_FRAME = MAX_FRAME_DEF,
   localparam int CW        = $clog2(MAX_FRAME + 1),
   localparam int SW        = sample_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [SW-1:0] s0_data,
   input  logic          s0_valid,
   input  logic          s0_last,
   output logic          s0_ready,
   input  logic [SW-1:0] s1_data,
   input  logic          s1_valid,
   input  logic          s1_last,
   output logic          s1_ready,
   output logic [SW-1:0] m_data,
   output logic          m_valid,
   output logic          m_last,
   input  logic          m_ready,
   output logic          m_src,
   output logic          busy,
   output logic          err_trunc
);

   arb_state_e     state_q,   state_d;
   src_id_t        owner_q,   owner_d;
   src_id_t        rr_last_q, rr_last_d;
   logic [CW-1:0]  sym_cnt_q, sym_cnt_d;
   logic           err_q,     err_d;

   logic           out_free;
   logic           sel_valid;
   logic           sel_last;
   logic [SW-1:0]  sel_data;
   logic           accept;
   logic           at_limit;
   logic           beat_last;
   meta_t          in_meta;
   meta_t          out_meta;

   // Owner's stream, selected by the registered grant.
   assign sel_valid = (owner_q == SRC1) ? s1_valid : s0_valid;
   assign sel_last  = (owner_q == SRC1) ? s1_last  : s0_last;
   assign sel_data  = (owner_q == SRC1) ? s1_data  : s0_data;

   // Readies depend only on registered state and m_ready, never on source valid.
   assign s0_ready = (state_q == ST_GRANT) && (owner_q == SRC0) && out_free;
   assign s1_ready = (state_q == ST_GRANT) && (owner_q == SRC1) && out_free;

   assign accept = (state_q == ST_GRANT) && sel_valid && out_free;

   // sym_cnt counts beats already accepted in this frame, so the beat being
   // accepted now is number sym_cnt+1; reaching MAX_FRAME closes the frame.
   assign at_limit  = (sym_cnt_q == CW'(MAX_FRAME - 1));
   assign beat_last = sel_last || at_limit;

   assign in_meta.last = beat_last;
   assign in_meta.src  = owner_q;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      sym_cnt_d = sym_cnt_q;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Grant decision only; no beat moves in this cycle.
            if (s0_valid || s1_valid) begin
               if (s0_valid && s1_valid) begin
                  owner_d = ~rr_last_q;
               end else if (s1_valid) begin
                  owner_d = SRC1;
               end else begin
                  owner_d = SRC0;
               end
               state_d   = ST_GRANT;
               sym_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            // Idle cycles from the owner keep the grant indefinitely.
            if (accept) begin
               sym_cnt_d = sym_cnt_q + CW'(1);
               if (beat_last) begin
                  state_d   = ST_IDLE;
                  rr_last_d = owner_q;
                  // A frame that ends by its own last exactly at the limit is not a truncation.
                  err_d     = at_limit && !sel_last;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= SRC0;
         rr_last_q <= SRC1;
         sym_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         sym_cnt_q <= sym_cnt_d;
         err_q     <= err_d;
      end
   end

   axis_out_reg #(
      .DW (SW)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .in_vld_i   (accept),
      .in_dat_i   (sel_data),
      .in_meta_i  (in_meta),
      .out_rdy_i  (m_ready),
      .out_vld_o  (m_valid),
      .out_dat_o  (m_data),
      .out_meta_o (out_meta),
      .free_o     (out_free)
   );

   assign m_last    = out_meta.last;
   assign m_src     = out_meta.src;
   assign busy      = (state_q == ST_GRANT);
   // Registered so the pulse lines up with the truncated beat on m_*.
   assign err_trunc = err_q;

endmodule

// File: tb/tb_qpsk_demap_arbiter.sv
// Self-checking bench for qpsk_demap_arbiter (MAX_FRAME=8 so the frame limit is reachable).
// Latency: n/a.
// Backpressure: m_ready driven as always-1, random, or a 1,0,0 repeating pattern.
module tb_qpsk_demap_arbiter;

   localparam int N    = 16;
   localparam int MAXF = 8;
   localparam int SW   = 2 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] s0_data, s1_data, m_data;
   logic          s0_valid, s0_last, s0_ready;
   logic          s1_valid, s1_last, s1_ready;
   logic          m_valid, m_last, m_ready, m_src, busy, err_trunc;

   always #5 clk = ~clk;

   qpsk_demap_arbiter #(
      .N         (N),
      .MAX_FRAME (MAXF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s0_data   (s0_data),
      .s0_valid  (s0_valid),
      .s0_last   (s0_last),
      .s0_ready  (s0_ready),
      .s1_data   (s1_data),
      .s1_valid  (s1_valid),
      .s1_last   (s1_last),
      .s1_ready  (s1_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .m_src     (m_src),
      .busy      (busy),
      .err_trunc (err_trunc)
   );

   typedef struct packed {
      logic [SW-1:0] d;
      logic          l;
   } sbeat_t;

   typedef struct packed {
      logic [SW-1:0] d;
      logic          l;
      logic          s;
      logic [1:0]    e;
   } obeat_t;

   typedef struct {
      int src;
      int len;
      int rmode;
      int exp_chunks;
      int exp_errs;
   } vec_t;

   sbeat_t q0[$], q1[$];
   obeat_t got[$], expq[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     pos0, pos1, bubble_pct, rmode, rcnt, acc0, err_cnt;
   logic   mdl_rr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_srcs();
      if (q0.size() > 0) begin
         s0_data  = q0[0].d;
         s0_last  = q0[0].l;
         s0_valid = (pos0 == 0) || ($urandom_range(99) >= bubble_pct);
      end else begin
         s0_data = '0; s0_last = 1'b0; s0_valid = 1'b0;
      end
      if (q1.size() > 0) begin
         s1_data  = q1[0].d;
         s1_last  = q1[0].l;
         s1_valid = (pos1 == 0) || ($urandom_range(99) >= bubble_pct);
      end else begin
         s1_data = '0; s1_last = 1'b0; s1_valid = 1'b0;
      end
      case (rmode)
         0: m_ready = 1'b1;
         1: m_ready = ($urandom_range(1) == 1);
         default: begin
            m_ready = ((rcnt % 3) == 0);
            rcnt++;
         end
      endcase
   endtask

   // One clock: observe at negedge, advance sources just after posedge.
   task automatic cycle();
      logic x0, x1, mx;
      @(negedge clk);
      x0 = s0_valid && s0_ready;
      x1 = s1_valid && s1_ready;
      mx = m_valid && m_ready;
      if (s0_ready && s1_ready) chk("both_ready", 1, 0);
      if (m_valid && !m_ready) chk("ready_while_full", {s0_ready, s1_ready}, 0);
      if (m_valid && got.size() < expq.size()) begin
         chk("beat_data", m_data, expq[got.size()].d);
         chk("beat_last_src", {m_last, m_src}, {expq[got.size()].l, expq[got.size()].s});
      end
      if (err_trunc) begin
         err_cnt++;
         chk("err_with_last", {m_valid, m_last}, 2'b11);
      end
      if (mx) begin
         got.push_back('{m_data, m_last, m_src, 2'(err_cnt)});
         err_cnt = 0;
      end
      @(posedge clk);
      #1;
      if (x0) begin
         pos0 = (q0[0].l || (pos0 + 1 == MAXF)) ? 0 : pos0 + 1;
         void'(q0.pop_front());
         acc0++;
      end
      if (x1) begin
         pos1 = (q1[0].l || (pos1 + 1 == MAXF)) ? 0 : pos1 + 1;
         void'(q1.pop_front());
      end
      drive_srcs();
   endtask

   task automatic add_frame(input int src, input int len);
      sbeat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = $urandom;
         b.l = (i == len - 1);
         if (src == 1) q1.push_back(b); else q0.push_back(b);
      end
   endtask

   // Reference: split each source's symbol stream into frames at last or at
   // MAXF symbols, then alternate sources while both have frames pending.
   function automatic void build_exp();
      int     i0, i1, n0, n1, cnt;
      logic   pick, capl, done;
      sbeat_t b;
      i0 = 0; i1 = 0; n0 = q0.size(); n1 = q1.size();
      expq.delete();
      while (i0 < n0 || i1 < n1) begin
         if (i0 < n0 && i1 < n1) pick = ~mdl_rr;
         else pick = (i0 < n0) ? 1'b0 : 1'b1;
         cnt  = 0;
         done = 1'b0;
         while (!done) begin
            if (pick) begin b = q1[i1]; i1++; end
            else begin b = q0[i0]; i0++; end
            cnt++;
            capl = (cnt == MAXF);
            expq.push_back('{b.d, b.l || capl, pick, (capl && !b.l) ? 2'd1 : 2'd0});
            done = b.l || capl || (pick ? (i1 >= n1) : (i0 >= n0));
         end
         mdl_rr = pick;
      end
   endfunction

   task automatic run_scn(input string name);
      int budget, lim;
      budget = 0;
      build_exp();
      got.delete();
      err_cnt = 0;
      drive_srcs();
      while ((q0.size() > 0 || q1.size() > 0 || got.size() < expq.size()) && budget < 3000) begin
         cycle();
         budget++;
      end
      chk({name, "_count"}, got.size(), expq.size());
      lim = (got.size() < expq.size()) ? got.size() : expq.size();
      for (int i = 0; i < lim; i++) chk({name, "_beat"}, got[i], expq[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t tbl[7];
      logic [SW-1:0] vv[4];
      int chunks, errs, b;

      tbl[0] = '{0,  4, 0, 1, 0};   // plain frame
      tbl[1] = '{1,  1, 0, 1, 0};   // single-beat frame
      tbl[2] = '{1, 11, 0, 2, 1};   // runaway: cut at 8, then 3-beat remainder
      tbl[3] = '{0,  8, 1, 1, 0};   // last exactly at the limit
      tbl[4] = '{1,  5, 2, 1, 0};   // back-pressure 1,0,0 pattern
      tbl[5] = '{0, 16, 1, 2, 1};   // cut at 8, remainder ends on its own last at 8
      tbl[6] = '{1,  9, 2, 2, 1};   // cut at 8, one-beat remainder
      vv[0] = 32'h0001_0001; vv[1] = 32'hFFFF_0001;
      vv[2] = 32'h0001_FFFF; vv[3] = 32'hFFFF_FFFF;

      rst = 1'b1; m_ready = 1'b1; rcnt = 0; bubble_pct = 0; rmode = 0;
      s0_valid = 1'b1; s1_valid = 1'b1; s0_last = 1'b0; s1_last = 1'b0;
      s0_data = '0; s1_data = '0; pos0 = 0; pos1 = 0; acc0 = 0; err_cnt = 0;
      mdl_rr = 1'b1;

      // Reset state, with both sources requesting.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_src", m_src, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_trunc, 0);
      chk("rst_readys", {s0_ready, s1_ready}, 0);
      rst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
      @(posedge clk);
      #1;

      // Single source, cycle-exact latency and busy timing.
      s0_valid = 1'b1; s0_data = vv[0]; s0_last = 1'b0;
      @(posedge clk);
      #1;
      chk("a_grant_busy", busy, 1);
      chk("a_grant_ready", {s0_ready, s1_ready}, 2'b10);
      chk("a_grant_mvalid", m_valid, 0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk("a_mvalid", m_valid, 1);
         chk("a_mdata", m_data, vv[k]);
         chk("a_mlast", m_last, (k == 3));
         chk("a_msrc", m_src, 0);
         chk("a_busy", busy, (k != 3));
         if (k < 3) begin
            s0_data = vv[k+1]; s0_last = (k + 1 == 3);
         end else begin
            s0_valid = 1'b0; s0_last = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("a_release", m_valid, 0);
      mdl_rr = 1'b0;

      // Contention from reset: s0, s1, s0, s1.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; mdl_rr = 1'b1; pos0 = 0; pos1 = 0;
      add_frame(0, 3); add_frame(0, 3); add_frame(1, 3); add_frame(1, 3);
      run_scn("contention");
      if (got.size() == 12) begin
         chk("order", {got[0].s, got[3].s, got[6].s, got[9].s}, 4'b0101);
      end else begin
         chk("order_len", got.size(), 12);
      end

      // Table of single-source frame scenarios.
      for (int t = 0; t < 7; t++) begin
         rmode = tbl[t].rmode; rcnt = 0;
         add_frame(tbl[t].src, tbl[t].len);
         run_scn("tbl");
         chunks = 0; errs = 0;
         foreach (got[i]) begin
            if (got[i].l) chunks++;
            errs += int'(got[i].e);
         end
         chk("tbl_chunks", chunks, tbl[t].exp_chunks);
         chk("tbl_errs", errs, tbl[t].exp_errs);
      end

      // Reset after beat 2 of a 6-beat s0 frame.
      rmode = 0; bubble_pct = 0; expq.delete(); got.delete(); acc0 = 0;
      add_frame(0, 6);
      drive_srcs();
      b = 0;
      while (acc0 < 2 && b < 50) begin
         cycle();
         b++;
      end
      chk("rst_mid_acc", acc0, 2);
      rst = 1'b1; q0.delete(); pos0 = 0;
      drive_srcs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rstmid_mvalid", m_valid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_readys", {s0_ready, s1_ready}, 0);
      mdl_rr = 1'b1;
      add_frame(1, 3);
      run_scn("post_rst");

      // Random traffic with bubbles and random back-pressure.
      bubble_pct = 30; rmode = 1;
      for (int it = 0; it < 4; it++) begin
         for (int f = 0; f < int'($urandom_range(3, 1)); f++) add_frame(0, int'($urandom_range(12, 1)));
         for (int f = 0; f < int'($urandom_range(3, 1)); f++) add_frame(1, int'($urandom_range(12, 1)));
         run_scn("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
